// File: rtl/matmul_pkg.sv
// Shared types and helpers for the systolic matrix multiplier.
// No timing of its own; the types here are used by the top and the PE.
// No flow control; these are pure declarations.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Wide enough to sum N full-scale products without losing the sign.
  function automatic int default_acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  // Low dw bits hold the saturation value: unsigned max, signed max, or signed min.
  function automatic logic [63:0] sat_bound(input logic sgn, input logic neg, input int dw);
    logic [63:0] mag;
    mag = (64'd1 << (sgn ? dw - 1 : dw)) - 64'd1;
    if (sgn && neg) begin
      return ~mag;
    end
    return mag;
  endfunction

endpackage

// File: rtl/matmul_pe.sv
// One systolic PE: forwards a right and b down through registers and accumulates a*b.
// Latency: 1 cycle per hop; acc_d exposes the accumulator value that the next edge stores.
// No backpressure; en=0 holds all state, clr zeroes the accumulator, flush empties the pass-through registers.
module matmul_pe
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  flush,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc_d
);

  localparam int EXT = ACC_WIDTH - DATA_WIDTH;

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] b_ext;
  logic [ACC_WIDTH-1:0] prod;

  // Extending to the full accumulator width makes one unsigned multiply correct in both modes.
  assign a_ext = signed_mode ? {{EXT{a_in[DATA_WIDTH-1]}}, a_in} : {{EXT{1'b0}}, a_in};
  assign b_ext = signed_mode ? {{EXT{b_in[DATA_WIDTH-1]}}, b_in} : {{EXT{1'b0}}, b_in};
  assign prod  = a_ext * b_ext;

  always_comb begin
    acc_d = acc;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc + prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      acc <= acc_d;
      if (flush) begin
        a_out <= '0;
        b_out <= '0;
      end else if (en) begin
        a_out <= a_in;
        b_out <= b_in;
      end
    end
  end

endmodule

// File: rtl/systolic_matmul.sv
// Output-stationary systolic array computing C = A*B (or C += A*B); MATMUL_SAT_EN selects saturating results.
// Latency: 1 LOAD cycle + (M+N+P-2) RUN cycles, then a 1-cycle DONE pulse.
// No backpressure; start is accepted only in IDLE and is never queued.
module systolic_matmul
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int P          = 8,
  parameter int ACC_WIDTH  = default_acc_width(DATA_WIDTH, N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      acc_en,
  input  logic                      signed_mode,
  input  logic [M*N*DATA_WIDTH-1:0] matrix_a,
  input  logic [N*P*DATA_WIDTH-1:0] matrix_b,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [M*P*DATA_WIDTH-1:0] result_c
);

  localparam int RUN_LEN = M + N + P - 2;
  localparam int CNT_W   = $clog2(M + N + P);

  state_t                    state;
  state_t                    state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic                      last_run;
  logic [M*N*DATA_WIDTH-1:0] a_cap;
  logic [N*P*DATA_WIDTH-1:0] b_cap;
  logic                      acc_en_cap;
  logic                      sgn_cap;
  logic                      pe_en;
  logic                      pe_clr;
  logic                      pe_flush;

  logic [DATA_WIDTH-1:0]     feed_a [M];
  logic [DATA_WIDTH-1:0]     feed_b [P];
  logic [DATA_WIDTH-1:0]     a_h    [M][P+1];
  logic [DATA_WIDTH-1:0]     b_v    [M+1][P];
  logic [ACC_WIDTH-1:0]      acc_d  [M][P];
  logic [M*P*DATA_WIDTH-1:0] res_nxt;
  logic [M*P-1:0]            ovf_vec;

  assign last_run = (state == RUN) && (cnt == CNT_W'(RUN_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (last_run) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == LOAD) || (state == RUN);
    done     = (state == DONE);
    pe_en    = (state == RUN);
    pe_flush = (state == LOAD);
    pe_clr   = (state == LOAD) && !acc_en_cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cap      <= '0;
      b_cap      <= '0;
      acc_en_cap <= 1'b0;
      sgn_cap    <= 1'b0;
    end else if (state == IDLE && start) begin
      a_cap      <= matrix_a;
      b_cap      <= matrix_b;
      acc_en_cap <= acc_en;
      sgn_cap    <= signed_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Row i sees A[i][k] at RUN cycle i+k and column j sees B[k][j] at cycle j+k, so operand pairs meet in PE(i,j).
  always_comb begin
    for (int i = 0; i < M; i++) feed_a[i] = '0;
    for (int j = 0; j < P; j++) feed_b[j] = '0;
    if (state == RUN) begin
      for (int i = 0; i < M; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(cnt) == i + k) feed_a[i] = a_cap[(i*N+k)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      for (int j = 0; j < P; j++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(cnt) == j + k) feed_b[j] = b_cap[(k*P+j)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_row_edge
    logic unused_a;
    assign a_h[i][0] = feed_a[i];
    assign unused_a  = ^a_h[i][P];
  end

  for (genvar j = 0; j < P; j++) begin : g_col_edge
    logic unused_b;
    assign b_v[0][j] = feed_b[j];
    assign unused_b  = ^b_v[M][j];
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < P; j++) begin : g_col
      logic [ACC_WIDTH-1:0]  acc;
      logic [DATA_WIDTH-1:0] res_e;
      logic                  ovf_e;

      matmul_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (pe_en),
        .clr        (pe_clr),
        .flush      (pe_flush),
        .signed_mode(sgn_cap),
        .a_in       (a_h[i][j]),
        .b_in       (b_v[i][j]),
        .a_out      (a_h[i][j+1]),
        .b_out      (b_v[i+1][j]),
        .acc_d      (acc_d[i][j])
      );

      assign acc = acc_d[i][j];
      // Representable iff the bits above the element are a pure sign (signed) or zero (unsigned) extension.
      assign ovf_e = sgn_cap ? !((&acc[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|acc[ACC_WIDTH-1:DATA_WIDTH-1]))
                             : (|acc[ACC_WIDTH-1:DATA_WIDTH]);

`ifdef MATMUL_SAT_EN
      logic [63:0] bound;
      logic        unused_bound;
      assign bound        = sat_bound(sgn_cap, acc[ACC_WIDTH-1], DATA_WIDTH);
      assign unused_bound = ^bound[63:DATA_WIDTH];
      assign res_e        = ovf_e ? bound[DATA_WIDTH-1:0] : acc[DATA_WIDTH-1:0];
`else
      assign res_e = acc[DATA_WIDTH-1:0];
`endif

      assign res_nxt[(i*P+j)*DATA_WIDTH +: DATA_WIDTH] = res_e;
      assign ovf_vec[i*P+j] = ovf_e;
    end
  end

  // acc_d already includes the final MAC landing on this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_c <= '0;
      overflow <= 1'b0;
    end else if (last_run) begin
      result_c <= res_nxt;
      overflow <= |ovf_vec;
    end
  end

endmodule

// File: doc/systolic_matmul.md
SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/result element width.
REQ-002 SHALL have parameters M, N, P, default 8 each, for C[MxP] = A[MxN] x B[NxP].
REQ-003 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+$clog2(N)+1, internal accumulator width.
REQ-004 SHALL have ports in this order:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request an operation.
- acc_en  in  1  sampled with start; 1 = C += A*B, 0 = C = A*B.
- signed_mode  in  1  sampled with start; 1 = two's-complement operands, 0 = unsigned.
- matrix_a  in  M*N*DATA_WIDTH  element A[i][k] at bits (i*N+k)*DATA_WIDTH.
- matrix_b  in  N*P*DATA_WIDTH  element B[k][j] at bits (k*P+j)*DATA_WIDTH.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  some element was not representable in DATA_WIDTH.
- result_c  out  M*P*DATA_WIDTH  element C[i][j] at bits (i*P+j)*DATA_WIDTH.

Function
REQ-005 SHALL use FSM states IDLE, LOAD, RUN, DONE; reset state IDLE.
REQ-006 IDLE->LOAD when start=1; matrix_a, matrix_b, acc_en and signed_mode are captured on that edge.
REQ-007 LOAD SHALL last 1 cycle: clear PE accumulators if acc_en=0, retain them if acc_en=1; then go to RUN.
REQ-008 RUN SHALL last M+N+P-2 cycles, driven by a cycle counter; A rows feed from the left skewed by row index, B columns feed from the top skewed by column index, zeros outside the valid window.
REQ-009 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-010 done SHALL be high exactly M+N+P cycles after the start-sampling edge (24 at defaults).
REQ-011 busy SHALL be 1 in LOAD and RUN, 0 in IDLE and DONE.
REQ-012 start outside IDLE SHALL be ignored and never queued; start held high in IDLE re-triggers each time IDLE is re-entered.
REQ-013 Operands SHALL be sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to ACC_WIDTH before multiplication; accumulation SHALL wrap modulo 2^ACC_WIDTH.
REQ-014 result_c and overflow SHALL update on the edge entering DONE and hold until the next DONE; matrix_a/matrix_b changes after capture SHALL have no effect.
REQ-015 overflow SHALL be 1 iff some accumulator lies outside the DATA_WIDTH range for the captured signed_mode.

Reset
REQ-016 rst_n=0 SHALL immediately force IDLE and clear counter, accumulators, result_c, busy, done and overflow to 0, including mid-RUN; the aborted operation produces no done.

Configuration
REQ-017 With MATMUL_SAT_EN defined, each result element SHALL saturate to the DATA_WIDTH min/max for the captured signed_mode; without it, each element SHALL be acc[DATA_WIDTH-1:0]. overflow behaves identically in both builds.

Structure
REQ-018 Package matmul_pkg SHALL hold the state enum, the default ACC_WIDTH function and the saturation helper.
REQ-019 Sub-module matmul_pe SHALL implement one PE: registered a/b pass-through, MAC, clear and hold controls; instantiated M*P times.

Verification
REQ-020 Defaults, signed, acc_en=0, A[i][k]=i*N+k mod 16, B[k][j]=(k*P+j+1) mod 16 -> done at cycle 24; result_c equals the truncated (no-SAT build) reference model.
REQ-021 A=identity, B arbitrary, acc_en=0, then repeat with acc_en=1 -> second result = 2*B element-wise; overflow=0 while 2*B fits.
REQ-022 Signed, all A=B=-128 (0x80), N=8 -> overflow=1; SAT build gives 0x7F everywhere, no-SAT build gives 0x00.
REQ-023 Unsigned, all A=B=0xFF -> overflow=1; SAT build gives 0xFF, no-SAT build gives 0x08 (8*0xFE01 mod 256).
REQ-024 start pulsed during RUN -> ignored, single done; rst_n low at RUN cycle 5 -> busy, done and result_c = 0 immediately; no done follows.
REQ-025 M=2, N=3, P=4, DATA_WIDTH=16 random signed -> matches the reference model; done at cycle 9.
